// File: rtl/seatbelt_chime_ctrl.sv
// Seatbelt chime controller: synchronises the raw alarm level, qualifies it,
// then plays a fixed beep pattern and holds the warning lamp until the alarm clears.
module seatbelt_chime_ctrl #(
   parameter int QUAL_CYC = 4,
   parameter int ON_CYC   = 3,
   parameter int OFF_CYC  = 2,
   parameter int BEEPS    = 3
) (
   input  logic Clk,
   input  logic nRst,
   input  logic Alarm,
   input  logic Ack,
   output logic Chime,
   output logic Lamp,
   output logic Busy
);

   localparam int MAX_QO  = (QUAL_CYC > ON_CYC) ? QUAL_CYC : ON_CYC;
   localparam int MAX_CYC = (MAX_QO > OFF_CYC) ? MAX_QO : OFF_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int BW      = $clog2(BEEPS + 1);

   localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYC - 1);
   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEPS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_QUAL = 3'd1;
   localparam logic [2:0] S_ON   = 3'd2;
   localparam logic [2:0] S_OFF  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic          s1, s2;
   logic          alarm_sync;
   logic [2:0]    state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [BW-1:0] beeps, beeps_d;

   assign alarm_sync = s2;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= Alarm;
         s2 <= s1;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      beeps_d = beeps;
      if (state == S_IDLE) begin
         if (alarm_sync) begin
            state_d = S_QUAL;
            cnt_d   = '0;
         end
      end else if (!alarm_sync) begin
         // Alarm clearing beats acknowledge and counting in every active state.
         state_d = S_IDLE;
         cnt_d   = '0;
         beeps_d = '0;
      end else if (Ack && state != S_HOLD) begin
         state_d = S_HOLD;
         cnt_d   = '0;
      end else begin
         case (state)
            S_QUAL: begin
               if (cnt == QUAL_LAST) begin
                  state_d = S_ON;
                  cnt_d   = '0;
                  beeps_d = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            S_ON: begin
               if (cnt == ON_LAST) begin
                  cnt_d   = '0;
                  beeps_d = beeps + 1'b1;
                  // Last beep goes straight to HOLD with no trailing gap.
                  state_d = (beeps == BEEP_LAST) ? S_HOLD : S_OFF;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            S_OFF: begin
               if (cnt == OFF_LAST) begin
                  state_d = S_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            default: begin
               state_d = state;
            end
         endcase
      end
   end

   // NOTE: async reset clears all state so outputs drop without waiting for a clock.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state <= S_IDLE;
         cnt   <= '0;
         beeps <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         beeps <= beeps_d;
      end
   end

   assign Chime = (state == S_ON);
   assign Lamp  = (state == S_ON) || (state == S_OFF) || (state == S_HOLD);
   assign Busy  = (state != S_IDLE);

endmodule

// File: tb/tb_seatbelt_chime_ctrl.sv
// Scoreboard bench for seatbelt_chime_ctrl: directed alarm/ack timelines with
// hand-computed per-edge expectations, checked by an independent monitor.
module tb_seatbelt_chime_ctrl;

   logic Clk = 1'b0;
   logic nRst = 1'b0;
   logic alarm_a = 1'b0, ack_a = 1'b0;
   logic alarm_b = 1'b0, ack_b = 1'b0;
   logic chime_a, lamp_a, busy_a;
   logic chime_b, lamp_b, busy_b;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit         sel;
      logic [2:0] exp;
      string      name;
   } sb_t;

   sb_t sb[$];

   seatbelt_chime_ctrl dut_a (
      .Clk(Clk), .nRst(nRst), .Alarm(alarm_a), .Ack(ack_a),
      .Chime(chime_a), .Lamp(lamp_a), .Busy(busy_a)
   );

   seatbelt_chime_ctrl #(.QUAL_CYC(1), .ON_CYC(1), .OFF_CYC(1), .BEEPS(1)) dut_b (
      .Clk(Clk), .nRst(nRst), .Alarm(alarm_b), .Ack(ack_b),
      .Chime(chime_b), .Lamp(lamp_b), .Busy(busy_b)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got chime/lamp/busy=%b expected %b", name, act, exp);
      end
   endtask

   function automatic logic bit_at(input string s, input int i);
      return s.getc(i) == 8'h31;
   endfunction

   // Monitor: compares DUT outputs at the falling edge against queued expectations.
   initial begin
      sb_t e;
      forever begin
         @(negedge Clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) check(e.name, {chime_b, lamp_b, busy_b}, e.exp);
            else       check(e.name, {chime_a, lamp_a, busy_a}, e.exp);
         end
      end
   end

   // Each string character is one rising edge: inputs sampled at edge i, outputs expected after it.
   task automatic run_seq(input string name, input bit sel, input string al, input string ak,
                          input string ch, input string lp, input string bs);
      sb_t e;
      for (int i = 0; i < al.len(); i++) begin
         if (sel) begin
            alarm_b = bit_at(al, i);
            ack_b   = bit_at(ak, i);
         end else begin
            alarm_a = bit_at(al, i);
            ack_a   = bit_at(ak, i);
         end
         @(posedge Clk);
         #1;
         e.sel  = sel;
         e.exp  = {bit_at(ch, i), bit_at(lp, i), bit_at(bs, i)};
         e.name = $sformatf("%s@edge%0d", name, i);
         sb.push_back(e);
      end
      ack_a = 1'b0;
      ack_b = 1'b0;
   endtask

   initial begin
      sb_t e;
      // Reset held with alarm high: both instances stay silent.
      alarm_a = 1'b1;
      alarm_b = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk);
         #1;
         e.exp = 3'b000;
         e.sel = 1'b0; e.name = $sformatf("reset_hold_a@%0d", i); sb.push_back(e);
         e.sel = 1'b1; e.name = $sformatf("reset_hold_b@%0d", i); sb.push_back(e);
      end
      alarm_a = 1'b0;
      alarm_b = 1'b0;
      @(posedge Clk);
      #1;
      nRst = 1'b1;
      repeat (3) @(posedge Clk);
      #1;

      run_seq("nominal", 1'b0,
              "11111111111111111111110000",
              "00000000000000000000000000",
              "00000011100111001110000000",
              "00000011111111111111111100",
              "00111111111111111111111100");

      run_seq("glitch", 1'b0,
              "11100000",
              "00000000",
              "00000000",
              "00000000",
              "00111000");

      run_seq("ack", 1'b0,
              "1111111111111111110000",
              "0000000000001000000000",
              "0000001110010000000000",
              "0000001111111111111100",
              "0011111111111111111100");

      run_seq("ack_vs_drop", 1'b0,
              "111111100000",
              "000000000100",
              "000000111000",
              "000000111000",
              "001111111000");

      run_seq("corner_rearm", 1'b1,
              "111111100011111110000",
              "000000000000000000000",
              "000100000000010000000",
              "000111111000011111100",
              "001111111000111111100");

      // Drive into BEEP_ON, then pull reset between clock edges.
      run_seq("pre_reset", 1'b0,
              "11111111",
              "00000000",
              "00000011",
              "00000011",
              "00111111");
      @(negedge Clk);
      #1;
      nRst = 1'b0;
      #1;
      check("async_reset_no_clk", {chime_a, lamp_a, busy_a}, 3'b000);
      repeat (2) @(posedge Clk);
      #1;
      check("reset_held_alarm_high", {chime_a, lamp_a, busy_a}, 3'b000);
      nRst = 1'b1;

      run_seq("post_reset", 1'b0,
              "11111111111111111111110000",
              "00000000000000000000000000",
              "00000011100111001110000000",
              "00000011111111111111111100",
              "00111111111111111111111100");

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge Clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
